vco_adc_ctrl: RTL and testbench

Capture sequencer for the `vco_adc` decimator. On a start request it:
- latches the oversample configuration and enables the ADC;
- discards the filter warm-up outputs;
- captures a programmed number of `data_out` words into an internal FIFO.

The FIFO is drained by a downstream consumer over a valid/ready interface. The block sits between the host/register interface and `vco_adc`, and owns the ADC's `oversample_in` and `enable_in` pins.

---
 rtl/vco_adc_ctrl_if.sv | 15 +
 rtl/vco_adc_ctrl.sv | 143 ++++++++++++++
 tb/tb_vco_adc_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/vco_adc_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vco_adc_ctrl_if : valid/ready read stream from the capture FIFO. Rev 1.0
// ---------------------------------------------------------------------------
interface vco_adc_ctrl_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] rd_data_out;
  logic                  rd_valid_out;
  logic                  rd_ready_in;

  modport master (output rd_data_out, output rd_valid_out, input rd_ready_in);
  modport slave  (input rd_data_out, input rd_valid_out, output rd_ready_in);
endinterface
`default_nettype wire

// File: rtl/vco_adc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vco_adc_ctrl : capture sequencer for vco_adc with a FWFT capture FIFO. Rev 1.0
// ---------------------------------------------------------------------------
module vco_adc_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int OSR_WIDTH  = 10,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DISCARD    = 3
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  input  wire logic                          start_in,
  input  wire logic                          abort_in,
  input  wire logic [OSR_WIDTH-1:0]          oversample_cfg_in,
  input  wire logic [CNT_WIDTH-1:0]          num_samples_in,
  output      logic [OSR_WIDTH-1:0]          adc_oversample_out,
  output      logic                          adc_enable_out,
  input  wire logic [DATA_WIDTH-1:0]         adc_data_in,
  input  wire logic                          adc_valid_in,
  vco_adc_ctrl_if.master                     rd_if,
  output      logic                          busy_out,
  output      logic                          done_out,
  output      logic                          overflow_out,
  output      logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

  localparam int c_aw     = $clog2(FIFO_DEPTH);
  localparam int c_disc_w = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_DISCARD = 3'd2,
    S_CAPTURE = 3'd3,
    S_STOP    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [OSR_WIDTH-1:0]  r_osr;
  logic [CNT_WIDTH-1:0]  r_remaining;
  logic [c_disc_w-1:0]   r_discard;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]       r_wr_ptr;
  logic [c_aw-1:0]       r_rd_ptr;
  logic [c_aw:0]         r_count;

  logic w_flush;
  logic w_full;
  logic w_pop;
  logic w_push_req;
  logic w_push;

  assign w_flush    = (r_state == S_IDLE) && start_in;
  assign w_full     = (r_count == (c_aw+1)'(FIFO_DEPTH));
  assign w_pop      = (r_count != '0) && rd_if.rd_ready_in;
  assign w_push_req = (r_state == S_CAPTURE) && adc_valid_in && !abort_in;
  // A full FIFO can still take a word when the consumer frees a slot on the same edge.
  assign w_push     = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_in) w_next = S_ARM;
      S_ARM: begin
        if (abort_in)                 w_next = S_IDLE;
        else if (r_remaining == '0)   w_next = S_STOP;
        else if (DISCARD == 0)        w_next = S_CAPTURE;
        else                          w_next = S_DISCARD;
      end
      S_DISCARD: begin
        if (abort_in)                                              w_next = S_IDLE;
        else if (adc_valid_in && (r_discard == c_disc_w'(1)))      w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort_in)                                              w_next = S_IDLE;
        else if (adc_valid_in && (r_remaining == CNT_WIDTH'(1)))   w_next = S_STOP;
      end
      S_STOP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_osr       <= '0;
      r_remaining <= '0;
      r_discard   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_flush) begin
        r_osr       <= oversample_cfg_in;
        r_remaining <= num_samples_in;
        r_overflow  <= 1'b0;
      end
      if (r_state == S_ARM) r_discard <= c_disc_w'(DISCARD);
      if (!abort_in && adc_valid_in) begin
        if (r_state == S_DISCARD) r_discard   <= r_discard - 1'b1;
        if (r_state == S_CAPTURE) r_remaining <= r_remaining - 1'b1;
      end
      if (w_push_req && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= adc_data_in;
  end

  assign adc_oversample_out = r_osr;
  assign adc_enable_out     = (r_state == S_DISCARD) || (r_state == S_CAPTURE);
  assign busy_out           = (r_state != S_IDLE);
  assign done_out           = (r_state == S_STOP);
  assign overflow_out       = r_overflow;
  assign fifo_count_out     = r_count;
  assign rd_if.rd_valid_out = (r_count != '0);
  assign rd_if.rd_data_out  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_vco_adc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vco_adc_ctrl : directed self-checking bench for vco_adc_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
module tb_vco_adc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic        abort_in;
  logic [9:0]  osr_cfg;
  logic [15:0] num_samples;
  logic [9:0]  adc_osr;
  logic        adc_en;
  logic [31:0] adc_data;
  logic        adc_valid;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [4:0]  fifo_count;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  vco_adc_ctrl_if #(.DATA_WIDTH(32)) rd_if ();

  vco_adc_ctrl #(
    .DATA_WIDTH(32), .OSR_WIDTH(10), .CNT_WIDTH(16), .FIFO_DEPTH(16), .DISCARD(3)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start_in           (start_in),
    .abort_in           (abort_in),
    .oversample_cfg_in  (osr_cfg),
    .num_samples_in     (num_samples),
    .adc_oversample_out (adc_osr),
    .adc_enable_out     (adc_en),
    .adc_data_in        (adc_data),
    .adc_valid_in       (adc_valid),
    .rd_if              (rd_if.master),
    .busy_out           (busy),
    .done_out           (done),
    .overflow_out       (overflow),
    .fifo_count_out     (fifo_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adc_word(input logic [31:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_osr"},   32'(adc_osr), 32'h0);
    check({tag, "_en"},    32'(adc_en), 32'h0);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_done"},  32'(done), 32'h0);
    check({tag, "_ovf"},   32'(overflow), 32'h0);
    check({tag, "_cnt"},   32'(fifo_count), 32'h0);
    check({tag, "_rdv"},   32'(rd_if.rd_valid_out), 32'h0);
    check({tag, "_rdd"},   rd_if.rd_data_out, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start_in = 1'b0; abort_in = 1'b0; osr_cfg = '0; num_samples = '0;
    adc_data = '0; adc_valid = 1'b0; rd_if.rd_ready_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_reset_values("reset");

    // Basic capture: 3 discarded words, 8 captured, consumer always ready
    osr_cfg = 10'h1FF; num_samples = 16'd8; rd_if.rd_ready_in = 1'b1;
    start_in = 1'b1; tick(); start_in = 1'b0;
    check("arm_busy", 32'(busy), 32'h1);
    check("arm_osr", 32'(adc_osr), 32'h1FF);
    check("arm_en", 32'(adc_en), 32'h0);
    tick();
    check("en_t2", 32'(adc_en), 32'h1);
    for (int i = 1; i <= 11; i++) begin
      repeat (19) tick();
      if (i == 11) check("en_before_last", 32'(adc_en), 32'h1);
      adc_word(32'(i));
      if (i >= 4) begin
        check("basic_rdv", 32'(rd_if.rd_valid_out), 32'h1);
        check("basic_rdd", rd_if.rd_data_out, 32'(i));
      end
      if (i == 5) begin
        start_in = 1'b1; osr_cfg = 10'h000; num_samples = 16'd1;
        tick(); start_in = 1'b0;
        check("ignored_start_osr", 32'(adc_osr), 32'h1FF);
      end
    end
    check("basic_done", 32'(done), 32'h1);
    check("basic_stop_en", 32'(adc_en), 32'h0);
    tick();
    check("basic_idle_done", 32'(done), 32'h0);
    check("basic_idle_busy", 32'(busy), 32'h0);
    check("basic_drained", 32'(rd_if.rd_valid_out), 32'h0);
    check("basic_done_cnt", 32'(done_cnt), 32'd1);

    // Overflow, with a push+pop on a full FIFO at word 16
    osr_cfg = 10'd5; num_samples = 16'd20; rd_if.rd_ready_in = 1'b0;
    start_in = 1'b1; tick(); start_in = 1'b0; tick();
    for (int d = 0; d < 3; d++) adc_word(32'(100 + d));
    for (int k = 0; k < 20; k++) begin
      if (k == 16) rd_if.rd_ready_in = 1'b1;
      adc_word(32'(200 + k));
      rd_if.rd_ready_in = 1'b0;
      if (k == 15) begin
        check("full_cnt", 32'(fifo_count), 32'd16);
        check("full_ovf", 32'(overflow), 32'h0);
      end
      if (k == 16) begin
        check("pushpop_cnt", 32'(fifo_count), 32'd16);
        check("pushpop_ovf", 32'(overflow), 32'h0);
        check("pushpop_head", rd_if.rd_data_out, 32'd201);
      end
      if (k == 17) check("ovf_set", 32'(overflow), 32'h1);
    end
    check("ovf_done", 32'(done), 32'h1);
    check("ovf_cnt_sat", 32'(fifo_count), 32'd16);
    tick();
    check("ovf_done_cnt", 32'(done_cnt), 32'd2);
    rd_if.rd_ready_in = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("ovf_drain", rd_if.rd_data_out, 32'(201 + k));
      tick();
    end
    check("ovf_empty_rdv", 32'(rd_if.rd_valid_out), 32'h0);
    check("ovf_empty_cnt", 32'(fifo_count), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'h1);
    rd_if.rd_ready_in = 1'b0;

    // Abort mid-capture after 5 words; abort beats the same-cycle valid
    num_samples = 16'd10;
    start_in = 1'b1; tick(); start_in = 1'b0;
    check("start_clears_ovf", 32'(overflow), 32'h0);
    tick();
    for (int d = 0; d < 3; d++) adc_word(32'(150 + d));
    for (int k = 0; k < 5; k++) adc_word(32'(300 + k));
    abort_in = 1'b1; adc_valid = 1'b1; adc_data = 32'd399;
    tick();
    abort_in = 1'b0; adc_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_en", 32'(adc_en), 32'h0);
    check("abort_cnt", 32'(fifo_count), 32'd5);
    check("abort_head", rd_if.rd_data_out, 32'd300);
    tick();
    check("abort_no_done", 32'(done_cnt), 32'd2);

    // Zero count: flushes the aborted words, never enables the ADC
    num_samples = 16'd0;
    start_in = 1'b1; tick(); start_in = 1'b0;
    check("zero_flush", 32'(fifo_count), 32'h0);
    check("zero_arm_en", 32'(adc_en), 32'h0);
    tick();
    check("zero_done", 32'(done), 32'h1);
    check("zero_stop_en", 32'(adc_en), 32'h0);
    tick();
    check("zero_idle", 32'(busy), 32'h0);
    check("zero_done_cnt", 32'(done_cnt), 32'd3);

    // Reset in the middle of the discard phase
    osr_cfg = 10'h2A; num_samples = 16'd7;
    start_in = 1'b1; tick(); start_in = 1'b0; tick();
    check("disc_en", 32'(adc_en), 32'h1);
    adc_word(32'd7);
    rst = 1'b1; tick(); rst = 1'b0;
    check_reset_values("midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
